// File: rtl/fetch_req_ctrl.sv
// Fetch request controller. Issues icache fetch requests under a credit scheme
// so the fetch buffer never overflows. It discards icache responses that
// belong to fetches killed by a flush.
module fetch_req_ctrl #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter logic [31:0] RESET_PC     = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        stall,
    input  logic [1:0]  pop_cnt,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_pc,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic        resp_two,
    output logic        buf_push,
    output logic        buf_push_two,
    output logic        buf_flush,
    output logic [4:0]  occupancy,
    output logic [1:0]  inflight
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_REDIR = 2'd2;

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic [4:0]  occ_q;
    logic [1:0]  infl_q;
    logic [1:0]  kill_cnt;

    logic        req_fire;
    logic        resp_acc;
    logic        resp_live;
    logic        resp_kill;
    logic [6:0]  credit_need;
    logic [3:0]  kill_add;
    logic [3:0]  kill_sum;
    logic [1:0]  kill_flush;
    logic [5:0]  occ_sum;
    logic [4:0]  occ_nxt;

    // Worst-case buffer usage if one more 2-instruction request is issued.
    assign credit_need = 7'(occ_q) + 7'({infl_q, 1'b0}) + 7'd2;

    assign req_valid = rstn && (state == S_RUN) && !flush && !stall
                    && ({1'b0, infl_q} < 3'(MAX_INFLIGHT))
                    && (credit_need <= 7'(DEPTH));
    assign req_pc    = fetch_pc;
    assign req_fire  = req_valid && req_ready;

    assign resp_ready = !stall;
    assign resp_acc   = rstn && resp_valid && resp_ready;
    assign resp_kill  = resp_acc && (kill_cnt != 2'd0);
    assign resp_live  = resp_acc && (kill_cnt == 2'd0);

    assign buf_push     = resp_live && !flush;
    assign buf_push_two = buf_push && resp_two;
    assign buf_flush    = rstn && flush;
    assign occupancy    = occ_q;
    assign inflight     = infl_q;

    // Stale-response count after a flush. Every live request becomes stale.
    // A response consumed in the flush cycle itself is no longer outstanding.
    always_comb begin
        kill_add = 4'(kill_cnt) + 4'(infl_q) + 4'(req_fire);
        if (kill_add < 4'(resp_acc))
            kill_sum = 4'd0;
        else
            kill_sum = kill_add - 4'(resp_acc);
        kill_flush = (kill_sum > 4'd3) ? 2'd3 : kill_sum[1:0];
    end

    // Buffer occupancy after this cycle's push and pop.
    always_comb begin
        occ_sum = 6'(occ_q) + (buf_push ? (buf_push_two ? 6'd2 : 6'd1) : 6'd0);
        occ_nxt = 5'(occ_sum - 6'(pop_cnt));
    end

    // State, fetch PC and credit counters. Flush overrides stall.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            occ_q    <= 5'd0;
            infl_q   <= 2'd0;
            kill_cnt <= 2'd0;
        end else if (flush) begin
            state    <= S_REDIR;
            fetch_pc <= flush_pc;
            occ_q    <= 5'd0;
            infl_q   <= 2'd0;
            kill_cnt <= kill_flush;
        end else begin
            if (!stall && (state != S_RUN))
                state <= S_RUN;
            if (req_fire)
                fetch_pc <= fetch_pc + (fetch_pc[2] ? 32'd4 : 32'd8);
            occ_q    <= occ_nxt;
            infl_q   <= infl_q + 2'(req_fire) - 2'(resp_live);
            kill_cnt <= kill_cnt - 2'(resp_kill);
        end
    end

endmodule
